// File: rtl/data_sram_responder.sv
// Slave end of the CPU SRAM-like data port: local word RAM, in-order
// responses after LATENCY cycles, up to QDEPTH requests outstanding.
module data_sram_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 1,
  parameter int QDEPTH  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  input  logic        stall_i,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] QD       = CW'(QDEPTH);
  localparam logic [PW-1:0] PLAST    = PW'(QDEPTH - 1);
  localparam logic [3:0]    CNT_INIT = 4'(LATENCY - 1);

  logic [31:0]       mem [2**ADDR_W];

  logic [QDEPTH-1:0] q_valid;
  logic [QDEPTH-1:0] q_wr;
  logic [3:0]        q_cnt   [QDEPTH];
  logic [31:0]       q_rdata [QDEPTH];

  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;

  logic [ADDR_W-1:0] widx;
  logic [3:0]        be;
  logic              push;
  logic              pop;
  logic              unused_addr_hi;

  // Upper address bits are deliberately dropped so addresses alias.
  assign widx           = data_sram_addr[ADDR_W+1:2];
  assign unused_addr_hi = ^data_sram_addr[31:ADDR_W+2];

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PLAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    be = 4'b1111;
    case (data_sram_size)
      2'd0:    be = 4'b0001 << data_sram_addr[1:0];
      2'd1:    be = data_sram_addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  assign pop  = resetn && !stall_i && q_valid[head] && (q_cnt[head] == 4'd0);
  assign push = resetn && !stall_i && data_sram_req && ((count < QD) || pop);

  assign data_sram_addr_ok = push;
  assign data_sram_data_ok = pop;
  assign data_sram_rdata   = (pop && !q_wr[head]) ? q_rdata[head] : '0;

  always_ff @(posedge clk) begin
    if (push && data_sram_wr) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  // A push into the slot being popped (full queue) must win, so it comes last.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      q_valid <= '0;
      q_wr    <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        q_cnt[i]   <= '0;
        q_rdata[i] <= '0;
      end
    end else begin
      if (!stall_i) begin
        for (int unsigned i = 0; i < QDEPTH; i++) begin
          if (q_valid[i] && (q_cnt[i] != 4'd0)) q_cnt[i] <= q_cnt[i] - 4'd1;
        end
      end
      if (pop) begin
        q_valid[head] <= 1'b0;
        head          <= ptr_next(head);
      end
      if (push) begin
        q_valid[tail] <= 1'b1;
        q_wr[tail]    <= data_sram_wr;
        q_cnt[tail]   <= CNT_INIT;
        q_rdata[tail] <= data_sram_wr ? '0 : mem[widx];
        tail          <= ptr_next(tail);
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: a virtual-time reference model
// predicts acceptance and response cycles; a monitor checks every cycle.
module tb_data_sram_responder;

  localparam int AW = 12;
  localparam int L  = 3;
  localparam int Q  = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        stall_i;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  data_sram_responder #(.ADDR_W(AW), .LATENCY(L), .QDEPTH(Q)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .stall_i           (stall_i),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    int unsigned due;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] mmem [int unsigned];
  int unsigned vt;          // count of non-stalled, non-reset cycles
  logic        exp_addr_ok;
  int          checks;
  int          errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference: one request is due 'L' unstalled cycles after acceptance,
  // and only when everything accepted before it has already answered.
  task automatic drive(input logic rq, input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input logic st);
    int unsigned idx;
    int unsigned lane;
    logic        head_pops;
    logic [31:0] cur;
    @(negedge clk);
    resetn          = 1'b1;
    data_sram_req   = rq;
    data_sram_wr    = wr;
    data_sram_size  = sz;
    data_sram_addr  = a;
    data_sram_wdata = wd;
    stall_i         = st;
    head_pops = 1'b0;
    if (!st && sb.size() > 0) head_pops = (sb[0].due <= vt);
    exp_addr_ok = rq && !st && ((sb.size() < Q) || head_pops);
    if (exp_addr_ok) begin
      idx = (a >> 2) % (1 << AW);
      if (wr) begin
        cur = mmem.exists(idx) ? mmem[idx] : 32'h0;
        if (sz == 2'd0) begin
          lane = a % 4;
          cur[8*lane +: 8] = wd[8*lane +: 8];
        end else if (sz == 2'd1) begin
          lane = ((a / 2) % 2) * 2;
          cur[8*lane +: 16] = wd[8*lane +: 16];
        end else begin
          cur = wd;
        end
        mmem[idx] = cur;
        sb.push_back('{rdata: 32'h0, due: vt + L});
      end else begin
        sb.push_back('{rdata: mmem[idx], due: vt + L});
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd);
    for (int n = 0; n < 20; n++) begin
      drive(1'b1, wr, sz, a, wd, 1'b0);
      if (exp_addr_ok) return;
    end
    checks++;
    errors++;
    $display("FAIL issue_timeout: request to %h never accepted", a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn        = 1'b0;
    data_sram_req = 1'b1;
    stall_i       = 1'b0;
    exp_addr_ok   = 1'b0;
    sb.delete();
  endtask

  initial begin : monitor
    logic exp_dok;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!resetn) begin
        chk("reset_addr_ok", {31'h0, data_sram_addr_ok}, 32'h0);
        chk("reset_data_ok", {31'h0, data_sram_data_ok}, 32'h0);
        chk("reset_rdata", data_sram_rdata, 32'h0);
        continue;
      end
      exp_dok = 1'b0;
      if (!stall_i && sb.size() > 0) exp_dok = (sb[0].due <= vt);
      chk("addr_ok", {31'h0, data_sram_addr_ok}, {31'h0, exp_addr_ok});
      chk("data_ok", {31'h0, data_sram_data_ok}, {31'h0, exp_dok});
      if (exp_dok) begin
        e = sb.pop_front();
        chk("rdata", data_sram_rdata, e.rdata);
      end else begin
        chk("rdata_idle", data_sram_rdata, 32'h0);
      end
      if (!stall_i) vt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  function automatic int unsigned pool_idx(input int unsigned k);
    return (k < 16) ? k : 4095 - (k - 16);
  endfunction

  initial begin
    logic        rq, wr, st;
    logic [1:0]  sz;
    logic [31:0] a, hi, wd;
    checks = 0; errors = 0; vt = 0; exp_addr_ok = 1'b0;
    resetn = 1'b0; data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_size = 2'd2;
    data_sram_addr = '0; data_sram_wdata = '0; stall_i = 1'b0;
    repeat (3) @(negedge clk);

    // word write then read in the next cycle
    issue(1'b1, 2'd2, 32'h100, 32'hDEADBEEF);
    issue(1'b0, 2'd2, 32'h100, 32'h0);
    idle(5);

    // byte and halfword merge into 0x11223344 -> 0x11ABCDEF
    issue(1'b1, 2'd2, 32'h0, 32'h11223344);
    issue(1'b1, 2'd0, 32'h2, 32'h00AB0000);
    issue(1'b1, 2'd1, 32'h0, 32'h0000CDEF);
    issue(1'b0, 2'd2, 32'h0, 32'h0);
    idle(5);

    // aliasing above the RAM index bits
    issue(1'b1, 2'd2, 32'h0000_4010, 32'hCAFEF00D);
    issue(1'b0, 2'd2, 32'h0000_0010, 32'h0);
    idle(5);

    // full queue: third read waits for the first pop
    drive(1'b1, 1'b0, 2'd2, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, 1'b0);
    issue(1'b0, 2'd2, 32'h10, 32'h0);
    idle(6);

    // stall for three cycles with req held high
    issue(1'b0, 2'd2, 32'h100, 32'h0);
    repeat (3) drive(1'b1, 1'b0, 2'd2, 32'h0, 32'h0, 1'b1);
    idle(6);

    // reset with two reads outstanding; RAM survives
    issue(1'b0, 2'd2, 32'h0, 32'h0);
    issue(1'b0, 2'd2, 32'h100, 32'h0);
    do_reset();
    idle(6);
    issue(1'b0, 2'd2, 32'h100, 32'h0);
    idle(5);

    // seed the random address pool with full words
    for (int unsigned k = 0; k < 20; k++) begin
      wd = $urandom;
      issue(1'b1, 2'd2, pool_idx(k) << 2, wd);
    end

    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      rq = ($urandom_range(0, 9) < 7);
      wr = ($urandom_range(0, 9) < 4);
      sz = 2'($urandom_range(0, 3));
      st = ($urandom_range(0, 9) == 0);
      hi = $urandom;
      wd = $urandom;
      a  = (hi & 32'hFFFF_C000) | (pool_idx($urandom_range(0, 19)) << 2) | (hi & 32'h3);
      drive(rq, wr, sz, a, wd, st);
    end
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
# data_sram_responder

Memory-side responder for the CPU's SRAM-like data port. It accepts read and write requests from the EXE/MEM side of the pipeline and returns in-order `data_ok`/`rdata` responses after a programmable latency. It holds a local word-addressed RAM and supports a bounded number of outstanding requests. It is the slave end of the interface the MEM stage consumes, and it serves as the data-memory model for the core testbench and the SoC-lite top.

## Interface
Parameters:
- `ADDR_W`, 12: word-index width; RAM depth is 2^ADDR_W words.
- `LATENCY`, 1: cycles from acceptance edge to `data_ok`; legal range 1..8.
- `QDEPTH`, 2: maximum outstanding requests; legal values 1, 2, 4.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `data_sram_req`  in  1: request valid.
- `data_sram_wr`  in  1: 1 = write, 0 = read.
- `data_sram_size`  in  2: 0 = byte, 1 = halfword, 2 = word, 3 = treated as word.
- `data_sram_addr`  in  32: byte address.
- `data_sram_wdata`  in  32: write data, already lane-aligned by the requester.
- `stall_i`  in  1: back-pressure injection. While high, no acceptance occurs and response countdowns hold.
- `data_sram_addr_ok`  out  1: request accepted this cycle.
- `data_sram_data_ok`  out  1: one response (read or write) completes this cycle.
- `data_sram_rdata`  out  32: read data, valid only when `data_ok` is high for a read; 0 otherwise.

## Operation
**Handshake**
- `addr_ok = resetn && !stall_i && req && (count < QDEPTH || pop)`. This is combinational.
- `pop = data_ok`.
- A request is accepted in any cycle with `req && addr_ok`.

**Queue**
- Circular FIFO of QDEPTH entries. Each entry holds `{wr, cnt[3:0], rdata[31:0]}`.
- Head and tail pointers wrap modulo QDEPTH.
- `count` is updated as +1 on push, −1 on pop, and unchanged when both happen in the same cycle.

**Acceptance edge**
- A write updates RAM word `addr[ADDR_W+1:2]` under byte enables.
- A read captures that RAM word into the entry's `rdata`. The read therefore observes every write accepted earlier.
- The entry's `cnt` is loaded with LATENCY−1.
- Address bits above `ADDR_W+1` are ignored, so addresses alias and wrap around.

**Byte enables** (`be[3:0]`)
- Size 0: `be = 4'b0001 << addr[1:0]`.
- Size 1: `be = addr[1] ? 4'b1100 : 4'b0011`; `addr[0]` is ignored.
- Size 2 or 3: `be = 4'b1111`.
- Reads always return the full word. Lane extraction belongs to the MEM stage.

**Countdown**
- Every cycle with `!stall_i`, each valid entry with `cnt != 0` decrements by 1, saturating at 0.

**Response**
- `data_ok = head valid && head.cnt == 0 && !stall_i`.
- `rdata = (data_ok && !head.wr) ? head.rdata : 32'b0`.
- The head pops on the same edge.
- Responses are strictly in acceptance order. Exactly one `data_ok` is issued per accepted request.
- There is no back-pressure on responses; the requester must consume `data_ok` in the cycle it is asserted.

**Reset**
- While `resetn = 0`: count, pointers and all entry valid bits are 0, and `addr_ok`, `data_ok` and `rdata` are 0.
- Outstanding requests are dropped; no late `data_ok` follows reset release.
- RAM contents are not reset.

## Timing
- LATENCY=1: a request in cycle k gets `addr_ok` in cycle k and `data_ok`/`rdata` in cycle k+1.
- Back-to-back accepts give one response per cycle at full throughput.
- General LATENCY=L, no stall: `data_ok` occurs L cycles after the accept cycle, or later if an older entry is still pending.
- Full queue (`count == QDEPTH`): `addr_ok` is 0 unless the head pops in the same cycle. With QDEPTH=1 and LATENCY=1 this still sustains one request per cycle.
- Simultaneous push and pop with `count == QDEPTH`: both happen, and `count` is unchanged.
- Empty queue: `data_ok` is 0.
- `stall_i` high for N cycles delays every pending response by exactly N cycles and blocks acceptance for those N cycles.
- Reset asserted mid-transfer: outputs go to 0 immediately (asynchronous). The first legal accept is in the first cycle with `resetn = 1`.

## Test plan
- Word write/read, LATENCY=1:
  - Stimulus: write 0xDEADBEEF to 0x100, then read 0x100 in the next cycle.
  - Required: `addr_ok` both cycles; write `data_ok` in cycle 2; read `data_ok` in cycle 3 with `rdata` = 0xDEADBEEF.
- Byte and halfword writes:
  - Stimulus: word 0x0 = 0x11223344. Write size 0 at addr 0x2 with wdata 0x00AB0000. Then write size 1 at addr 0x0 with wdata 0x0000CDEF.
  - Required: reading 0x0 returns 0x11ABCDEF.
- Full queue, QDEPTH=2, LATENCY=4:
  - Stimulus: 3 reads requested in consecutive cycles starting at cycle 0.
  - Required: `addr_ok` 1, 1, 0 in cycles 0–2. The third read is accepted in cycle 4, the pop cycle of read 1. `data_ok` occurs in cycles 4, 5 and 8.
- Stall injection, LATENCY=2:
  - Stimulus: accept a read in cycle 0 and hold `stall_i` high in cycles 1–3.
  - Required: `data_ok` moves from cycle 2 to cycle 5; `addr_ok` is 0 in cycles 1–3 even with `req` held high.
- Reset mid-operation:
  - Stimulus: 2 reads outstanding (LATENCY=3); pulse `resetn` low for one cycle.
  - Required: `data_ok` never asserts for the dropped reads; a fresh read after release returns the RAM contents written before reset.
- Aliasing, ADDR_W=12:
  - Stimulus: write 0xCAFEF00D to 0x0000_4010.
  - Required: reading 0x0000_0010 returns 0xCAFEF00D.
